ram_seq_ctrl: RTL and testbench

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_seq_ctrl_if.sv | 14 +
 rtl/dwell_timer.sv | 29 ++
 rtl/ram_seq_ctrl.sv | 108 ++++++++++
 tb/tb_ram_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants for the RAM fill/readback sequencer
package ram_pkg;

    localparam int DEPTH = 16;

    // Shown on the display in place of any readback word above 9
    localparam logic [3:0] NON_BCD = 4'hF;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_RD_REQ = 3'd2;
    localparam logic [2:0] S_RD_CAP = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    function automatic int unsigned addr_mod10(input int unsigned a);
        return a % 10;
    endfunction

endpackage

// File: rtl/ram_seq_ctrl_if.sv
// rtl/ram_seq_ctrl_if.sv - single-port RAM bus between sequencer and memory
interface ram_seq_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic              rden;
    logic [DATA_W-1:0] dato_write;
    logic [DATA_W-1:0] dato_read;

    modport master (output addr, wren, rden, dato_write, input dato_read);
    modport slave  (input addr, wren, rden, dato_write, output dato_read);
endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter flagging the last cycle of a dwell
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic tc_o
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;

    // Loaded with DWELL-1 so that tc_o lands on the DWELL-th counting cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign tc_o = count_i && (cnt_q == '0);

endmodule

// File: rtl/ram_seq_ctrl.sv
// rtl/ram_seq_ctrl.sv - fills a RAM with a digit pattern, then shows each word on a BCD display
module ram_seq_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 4,
    parameter int DWELL  = 2500000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wren_o,
    output logic              rden_o,
    output logic [DATA_W-1:0] dato_write_o,
    input  logic [DATA_W-1:0] dato_read_i,
    output logic [3:0]        bcd_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    logic [2:0]        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [3:0]        bcd_q;
    logic              err_q;
    logic              last_addr;
    logic              non_bcd;
    logic              dwell_tc;
    logic [DATA_W-1:0] fill_word;

    assign last_addr = &addr_q;
    assign non_bcd   = dato_read_i > DATA_W'(9);
    assign fill_word = mode_q ? fill_q : DATA_W'(addr_mod10(32'(addr_q)));

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (state_q == S_RD_CAP),
        .count_i (state_q == S_HOLD),
        .tc_o    (dwell_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_FILL;
                        mode_q  <= mode_i;
                        fill_q  <= data_i;
                        addr_q  <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (last_addr) begin
                        state_q <= S_RD_REQ;
                        addr_q  <= '0;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                S_RD_REQ: state_q <= S_RD_CAP;
                // RAM data is valid here, one cycle after the read request
                S_RD_CAP: begin
                    bcd_q   <= non_bcd ? NON_BCD : dato_read_i[3:0];
                    state_q <= S_HOLD;
                    if (non_bcd) begin
                        err_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (dwell_tc) begin
                        if (last_addr) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RD_REQ;
                            addr_q  <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign addr_o       = addr_q;
    assign wren_o       = (state_q == S_FILL);
    assign rden_o       = (state_q == S_RD_REQ);
    assign dato_write_o = wren_o ? fill_word : '0;
    assign bcd_o        = bcd_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb/tb_ram_seq_ctrl.sv - directed self-checking bench for ram_seq_ctrl
module tb_ram_seq_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int DWELL = 4;
    localparam int NW    = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          mode  = 1'b0;
    logic [DW-1:0] data  = '0;
    logic [3:0]    bcd;
    logic          busy;
    logic          done;
    logic          err;

    ram_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram ();

    ram_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DWELL(DWELL)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .mode_i       (mode),
        .data_i       (data),
        .addr_o       (ram.addr),
        .wren_o       (ram.wren),
        .rden_o       (ram.rden),
        .dato_write_o (ram.dato_write),
        .dato_read_i  (ram.dato_read),
        .bcd_o        (bcd),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // one-cycle-latency RAM
    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (ram.wren) mem[ram.addr] <= ram.dato_write;
        if (ram.rden) ram.dato_read <= mem[ram.addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus monitor, sampled on the falling edge
    logic          mon_clr = 1'b0;
    int            cyc = 0, wr_n = 0, rd_n = 0, cap_n = 0, done_n = 0;
    int            overlap_n = 0, gap_bad = 0, early_bad = 0, last_rd_cyc = -1;
    logic [AW-1:0] wr_addr_obs [32];
    logic [DW-1:0] wr_data_obs [32];
    logic [AW-1:0] rd_addr_obs [32];
    logic [3:0]    bcd_obs     [32];
    logic          s1 = 1'b0, s2 = 1'b0, rst_prev = 1'b0;
    logic [3:0]    bcd_prev = 4'h0;

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            wr_n = 0; rd_n = 0; cap_n = 0; done_n = 0;
            overlap_n = 0; gap_bad = 0; early_bad = 0; last_rd_cyc = -1;
            s1 = 1'b0; s2 = 1'b0;
        end else begin
            if (ram.wren && ram.rden) overlap_n++;
            if (ram.wren) begin
                if (wr_n < 32) begin
                    wr_addr_obs[wr_n] = ram.addr;
                    wr_data_obs[wr_n] = ram.dato_write;
                end
                wr_n++;
            end
            if (ram.rden) begin
                if (rd_n < 32) rd_addr_obs[rd_n] = ram.addr;
                rd_n++;
                if (last_rd_cyc >= 0 && (cyc - last_rd_cyc) != DWELL + 2) gap_bad++;
                last_rd_cyc = cyc;
            end
            if (s2) begin
                if (cap_n < 32) bcd_obs[cap_n] = bcd;
                cap_n++;
            end else if (!rst_prev && bcd !== bcd_prev) begin
                early_bad++;
            end
            if (done) done_n++;
            s2 = s1;
            s1 = ram.rden;
        end
        bcd_prev = bcd;
        rst_prev = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        tick();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic start_seq(input logic m, input logic [DW-1:0] d);
        clear_mon();
        mode  = m;
        data  = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 1'b0;
        data  = '0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic verify_run(input string tag, input logic m, input logic [DW-1:0] d);
        logic [3:0] ew;
        logic [3:0] eb;
        check({tag, "_writes"}, 32'(wr_n), 32'd16);
        check({tag, "_reads"}, 32'(rd_n), 32'd16);
        check({tag, "_captures"}, 32'(cap_n), 32'd16);
        check({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        check({tag, "_wr_rd_overlap"}, 32'(overlap_n), 32'd0);
        check({tag, "_read_spacing"}, 32'(gap_bad), 32'd0);
        check({tag, "_bcd_latency"}, 32'(early_bad), 32'd0);
        for (int i = 0; i < NW; i++) begin
            ew = m ? d : 4'(i % 10);
            eb = (ew > 4'd9) ? 4'hF : ew;
            check($sformatf("%s_wr_addr[%0d]", tag, i), 32'(wr_addr_obs[i]), 32'(i));
            check($sformatf("%s_wr_data[%0d]", tag, i), 32'(wr_data_obs[i]), 32'(ew));
            check($sformatf("%s_rd_addr[%0d]", tag, i), 32'(rd_addr_obs[i]), 32'(i));
            check($sformatf("%s_bcd[%0d]", tag, i), 32'(bcd_obs[i]), 32'(eb));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_addr"}, 32'(ram.addr), 32'd0);
        check({tag, "_wren"}, 32'(ram.wren), 32'd0);
        check({tag, "_rden"}, 32'(ram.rden), 32'd0);
        check({tag, "_wdata"}, 32'(ram.dato_write), 32'd0);
        check({tag, "_bcd"}, 32'(bcd), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int n;
        int n_rd;

        rst = 1'b1;
        repeat (3) tick();
        check_idle_zero("reset");
        rst = 1'b0;

        // mode 0: address mod 10
        start_seq(1'b0, 4'h0);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_wren_after_start", 32'(ram.wren), 32'd1);
        wait_done("t1");
        tick();
        check("t1_busy_idle", 32'(busy), 32'd0);
        verify_run("t1", 1'b0, 4'h0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_bcd_retained", 32'(bcd), 32'h5);

        // mode 1: constant 7
        start_seq(1'b1, 4'h7);
        wait_done("t2");
        tick();
        verify_run("t2", 1'b1, 4'h7);
        check("t2_err", 32'(err), 32'd0);

        // mode 1: non-BCD constant
        start_seq(1'b1, 4'hC);
        wait_done("t3");
        tick();
        verify_run("t3", 1'b1, 4'hC);
        repeat (3) tick();
        check("t3_err_sticky", 32'(err), 32'd1);
        check("t3_bcd_marker", 32'(bcd), 32'hF);

        // reset in the middle of FILL
        start_seq(1'b0, 4'h0);
        n = 0;
        while (!(ram.wren === 1'b1 && ram.addr === 4'd5) && n < 50) begin
            tick();
            n++;
        end
        check("t4_reached_addr5", 32'(ram.addr), 32'd5);
        rst = 1'b1;
        tick();
        check_idle_zero("t4_reset");
        rst = 1'b0;
        tick();
        check("t4_stays_idle", 32'(busy), 32'd0);
        start_seq(1'b0, 4'h0);
        wait_done("t4b");
        tick();
        verify_run("t4b", 1'b0, 4'h0);

        // start pulse during HOLD is ignored
        start_seq(1'b1, 4'h3);
        n = 0;
        n_rd = 0;
        while (n_rd < 3 && n < 200) begin
            tick();
            if (ram.rden) n_rd++;
            n++;
        end
        check("t5_third_read", 32'(n_rd), 32'd3);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy_after_pulse", 32'(busy), 32'd1);
        wait_done("t5");
        tick();
        verify_run("t5", 1'b1, 4'h3);

        // start held through DONE: accepted only on the following IDLE cycle
        clear_mon();
        mode  = 1'b0;
        start = 1'b1;
        wait_done("t6");
        tick();
        check("t6_idle_after_done", 32'(busy), 32'd0);
        tick();
        check("t6_restart_busy", 32'(busy), 32'd1);
        check("t6_restart_wren", 32'(ram.wren), 32'd1);
        check("t6_restart_addr", 32'(ram.addr), 32'd0);
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_reset_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
